// File: rtl/gate_truth_checker.sv
// Sweeps vectors 00,01,10,11 into a 2-input gate unit and scores its AND/OR/NOT outputs.
// done pulses 4*(SETTLE+2) cycles after the accepting edge; start is ignored while busy.
module gate_truth_checker #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       drv_a,
    output logic       drv_b,
    input  logic       obs_x,
    input  logic       obs_y,
    input  logic       obs_z,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic [3:0] fail_vec
);

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        WAIT,
        CHECK,
        FINISH
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state_q;
    logic [1:0] vec_q;
    logic [3:0] wait_q;
    logic       drv_a_q;
    logic       drv_b_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic [3:0] err_cnt_q;
    logic [3:0] fail_vec_q;

    logic       mism_x;
    logic       mism_y;
    logic       mism_z;
    logic       any_mism;
    logic [1:0] mism_cnt;
    logic [3:0] err_cnt_d;
    logic [1:0] vec_d;

    // Expected values come from the registered stimulus, so they stay stable through CHECK.
    always_comb begin
        mism_x    = obs_x ^ (drv_a_q & drv_b_q);
        mism_y    = obs_y ^ (drv_a_q | drv_b_q);
        mism_z    = obs_z ^ ~drv_a_q;
        any_mism  = mism_x | mism_y | mism_z;
        mism_cnt  = {1'b0, mism_x} + {1'b0, mism_y} + {1'b0, mism_z};
        err_cnt_d = err_cnt_q + {2'b00, mism_cnt};
        vec_d     = vec_q + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            vec_q      <= 2'd0;
            wait_q     <= 4'd0;
            drv_a_q    <= 1'b0;
            drv_b_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_cnt_q  <= 4'd0;
            fail_vec_q <= 4'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    busy_q  <= 1'b0;
                    drv_a_q <= 1'b0;
                    drv_b_q <= 1'b0;
                    if (start) begin
                        state_q    <= APPLY;
                        vec_q      <= 2'd0;
                        busy_q     <= 1'b1;
                        pass_q     <= 1'b0;
                        err_cnt_q  <= 4'd0;
                        fail_vec_q <= 4'd0;
                    end
                end
                APPLY: begin
                    state_q <= WAIT;
                    wait_q  <= 4'd0;
                end
                WAIT: begin
                    if (wait_q == SETTLE_LAST) begin
                        state_q <= CHECK;
                    end else begin
                        wait_q <= wait_q + 4'd1;
                    end
                end
                CHECK: begin
                    err_cnt_q <= err_cnt_d;
                    if (any_mism) begin
                        fail_vec_q[vec_q] <= 1'b1;
                    end
                    if (vec_q == 2'd3) begin
                        state_q <= FINISH;
                        done_q  <= 1'b1;
                        pass_q  <= (err_cnt_d == 4'd0);
                        drv_a_q <= 1'b0;
                        drv_b_q <= 1'b0;
                    end else begin
                        state_q <= APPLY;
                        vec_q   <= vec_d;
                        drv_a_q <= vec_d[1];
                        drv_b_q <= vec_d[0];
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign drv_a    = drv_a_q;
    assign drv_b    = drv_b_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign err_cnt  = err_cnt_q;
    assign fail_vec = fail_vec_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: SETTLE=1 and SETTLE=3 instances fed by a faultable gate unit.
module tb_gate_truth_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic sel = 1'b0;
    logic [1:0] mx = 2'd0, my = 2'd0, mz = 2'd0;

    logic drv_a1, drv_b1, obs_x1, obs_y1, obs_z1, busy1, done1, pass1;
    logic drv_a3, drv_b3, obs_x3, obs_y3, obs_z3, busy3, done3, pass3;
    logic [3:0] err1, fail1, err3, fail3;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Fault modes: 0 good, 1 stuck-at-0, 2 stuck-at-1, 3 inverted.
    function automatic logic flt(input logic v, input logic [1:0] m);
        case (m)
            2'd0: return v;
            2'd1: return 1'b0;
            2'd2: return 1'b1;
            default: return ~v;
        endcase
    endfunction

    assign obs_x1 = flt(drv_a1 & drv_b1, mx);
    assign obs_y1 = flt(drv_a1 | drv_b1, my);
    assign obs_z1 = flt(~drv_a1, mz);
    assign obs_x3 = flt(drv_a3 & drv_b3, mx);
    assign obs_y3 = flt(drv_a3 | drv_b3, my);
    assign obs_z3 = flt(~drv_a3, mz);

    logic start1, start3;
    assign start1 = sel ? 1'b0 : start;
    assign start3 = sel ? start : 1'b0;

    gate_truth_checker #(.SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .drv_a(drv_a1), .drv_b(drv_b1),
        .obs_x(obs_x1), .obs_y(obs_y1), .obs_z(obs_z1), .busy(busy1), .done(done1),
        .pass(pass1), .err_cnt(err1), .fail_vec(fail1)
    );

    gate_truth_checker #(.SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .drv_a(drv_a3), .drv_b(drv_b3),
        .obs_x(obs_x3), .obs_y(obs_y3), .obs_z(obs_z3), .busy(busy3), .done(done3),
        .pass(pass3), .err_cnt(err3), .fail_vec(fail3)
    );

    logic [1:0] c_drv;
    logic       c_busy, c_done, c_pass;
    logic [3:0] c_err, c_fail;
    assign c_drv  = sel ? {drv_a3, drv_b3} : {drv_a1, drv_b1};
    assign c_busy = sel ? busy3 : busy1;
    assign c_done = sel ? done3 : done1;
    assign c_pass = sel ? pass3 : pass1;
    assign c_err  = sel ? err3 : err1;
    assign c_fail = sel ? fail3 : fail1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scores the first nvec vectors straight from the truth table of AND/OR/NOT.
    task automatic model(input int nvec, output int e, output int f);
        e = 0;
        f = 0;
        for (int v = 0; v < nvec; v++) begin
            int a, b, n;
            bit ex, ey, ez;
            a = v / 2;
            b = v % 2;
            ex = (a == 1) && (b == 1);
            ey = (a == 1) || (b == 1);
            ez = (a == 0);
            n = 0;
            if (flt(ex, mx) != ex) n++;
            if (flt(ey, my) != ey) n++;
            if (flt(ez, mz) != ez) n++;
            e += n;
            if (n != 0) f |= (1 << v);
        end
    endtask

    // Caller sits at a negedge with the DUT idle; returns at the negedge after the accepting edge.
    task automatic start_sweep();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("accept_busy", c_busy, 1);
        chk("accept_drv", c_drv, 0);
        chk("accept_err", c_err, 0);
        chk("accept_fail", c_fail, 0);
    endtask

    // Follows the sweep to the done cycle, checking drv order/timing and latency.
    task automatic run_rest(input int s, input bit noisy);
        int n;
        logic [1:0] last;
        int pos[$];
        logic [1:0] seq[$];
        n = 0;
        last = c_drv;
        seq.push_back(c_drv);
        pos.push_back(0);
        while (!c_done && n < 200) begin
            start = noisy ? 1'($urandom_range(0, 2) == 0) : start;
            @(posedge clk);
            n++;
            @(negedge clk);
            if (!c_done && c_drv != last) begin
                seq.push_back(c_drv);
                pos.push_back(n);
                last = c_drv;
            end
        end
        if (noisy) start = 1'b0;
        chk("latency", n, 4 * (s + 2));
        chk("drv_changes", seq.size(), 4);
        for (int i = 0; i < seq.size() && i < 4; i++) begin
            chk("drv_seq", seq[i], i);
            chk("drv_pos", pos[i], i * (s + 2));
        end
    endtask

    task automatic check_done(input int e, input int f);
        chk("done_pulse", c_done, 1);
        chk("done_busy", c_busy, 1);
        chk("done_err", c_err, e);
        chk("done_fail", c_fail, f);
        chk("done_pass", c_pass, (e == 0));
        chk("done_drv", c_drv, 0);
    endtask

    task automatic check_idle(input int e, input int f);
        chk("idle_done", c_done, 0);
        chk("idle_busy", c_busy, 0);
        chk("idle_err", c_err, e);
        chk("idle_fail", c_fail, f);
        chk("idle_pass", c_pass, (e == 0));
    endtask

    task automatic do_sweep(input bit s3, input bit noisy);
        int e, f;
        sel = s3;
        model(4, e, f);
        start_sweep();
        run_rest(s3 ? 3 : 1, noisy);
        check_done(e, f);
        @(posedge clk);
        @(negedge clk);
        check_idle(e, f);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int e, f;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            sel = k[0];
            chk("rst_busy", c_busy, 0);
            chk("rst_done", c_done, 0);
            chk("rst_pass", c_pass, 0);
            chk("rst_err", c_err, 0);
            chk("rst_fail", c_fail, 0);
            chk("rst_drv", c_drv, 0);
        end

        // First start on the first edge with rst low, good gate unit.
        sel = 1'b0;
        rst = 1'b0;
        start_sweep();
        run_rest(1, 1'b0);
        check_done(0, 0);
        @(posedge clk);
        @(negedge clk);
        check_idle(0, 0);

        mz = 2'd1;
        do_sweep(1'b0, 1'b0);
        chk("z_stuck0_err", c_err, 2);
        chk("z_stuck0_fail", c_fail, 4'b0011);

        mx = 2'd2; my = 2'd1; mz = 2'd1;
        do_sweep(1'b0, 1'b0);
        chk("multi_stuck_err", c_err, 8);
        chk("multi_stuck_fail", c_fail, 4'b1111);

        // Reset during WAIT of vector 2 (edge 7 after accept for SETTLE=1).
        mx = 2'd0; my = 2'd0; mz = 2'd1;
        sel = 1'b0;
        start_sweep();
        repeat (7) begin
            @(posedge clk);
            @(negedge clk);
        end
        model(2, e, f);
        chk("pre_rst_err", c_err, e);
        chk("pre_rst_drv", c_drv, 2);
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        chk("midrst_busy", c_busy, 0);
        chk("midrst_drv", c_drv, 0);
        chk("midrst_err", c_err, 0);
        chk("midrst_fail", c_fail, 0);
        mz = 2'd0;
        do_sweep(1'b0, 1'b0);

        // Spurious starts while busy, then start held across done.
        my = 2'd1;
        sel = 1'b0;
        model(4, e, f);
        start_sweep();
        run_rest(1, 1'b1);
        check_done(e, f);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle(e, f);
        @(posedge clk);
        @(negedge clk);
        chk("held_accept_busy", c_busy, 1);
        chk("held_accept_err", c_err, 0);
        chk("held_accept_fail", c_fail, 0);
        chk("held_accept_pass", c_pass, 0);
        run_rest(1, 1'b0);
        start = 1'b0;
        check_done(e, f);
        @(posedge clk);
        @(negedge clk);
        check_idle(e, f);

        // Longer settle, good gate unit.
        mx = 2'd0; my = 2'd0; mz = 2'd0;
        do_sweep(1'b1, 1'b0);

        for (int it = 0; it < 10; it++) begin
            mx = 2'($urandom_range(0, 3));
            my = 2'($urandom_range(0, 3));
            mz = 2'($urandom_range(0, 3));
            do_sweep(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
